// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer giving the CPU controller and the DMA engine
// access to one variable-latency memory port, with a per-access watchdog.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ABORT_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic [2:0]        state,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSY_CPU = 3'd1,
    BUSY_DMA = 3'd2,
    RESP_CPU = 3'd3,
    RESP_DMA = 3'd4
  } state_t;

  // wait_cnt holds the number of BUSY cycles already spent without mem_ready
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     st, st_nx;
  logic       last_dma;
  logic [7:0] wait_cnt;
  logic       cpu_creq, pick_cpu, pick_dma, busy, timeout;

  assign cpu_creq = cpu_rd | cpu_wr;
  assign pick_cpu = cpu_creq & (~dma_req | last_dma);
  assign pick_dma = dma_req & (~cpu_creq | ~last_dma);
  assign busy     = (st == BUSY_CPU) | (st == BUSY_DMA);
  assign timeout  = ~mem_ready & (wait_cnt == TO_LAST);

  always_comb begin
    st_nx = st;
    case (st)
      IDLE: begin
        if (pick_cpu)      st_nx = BUSY_CPU;
        else if (pick_dma) st_nx = BUSY_DMA;
      end
      BUSY_CPU: if (mem_ready || timeout) st_nx = RESP_CPU;
      BUSY_DMA: if (mem_ready || timeout) st_nx = RESP_DMA;
      default:  st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      last_dma  <= 1'b1;
      wait_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      err       <= 1'b0;
    end else begin
      st <= st_nx;
      case (st)
        IDLE: begin
          wait_cnt <= '0;
          if (pick_cpu) begin
            mem_we    <= cpu_wr;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            last_dma  <= 1'b0;
          end else if (pick_dma) begin
            mem_we    <= dma_we;
            mem_addr  <= dma_addr;
            mem_wdata <= dma_wdata;
            last_dma  <= 1'b1;
          end
        end
        BUSY_CPU, BUSY_DMA: begin
          if (mem_ready || timeout) begin
            if (st == BUSY_CPU) cpu_rdata <= mem_ready ? mem_rdata : ABORT_DATA;
            else                dma_rdata <= mem_ready ? mem_rdata : ABORT_DATA;
            if (timeout) err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = busy;
  assign dma_ack   = (st == RESP_DMA);
  assign cpu_stall = cpu_creq & (st != RESP_CPU);
  assign state     = st;

  always_comb begin
    grant = 2'b00;
    if (st == BUSY_CPU || st == RESP_CPU) grant = 2'b01;
    if (st == BUSY_DMA || st == RESP_DMA) grant = 2'b10;
  end

endmodule
